// File: rtl/alu_if.sv
// Operand/opcode/result bundle between the multicycle datapath and its ALU.
interface alu_if;
  logic [31:0] A32;
  logic [31:0] B32;
  logic [3:0]  ALUop;
  logic [31:0] out32;
  logic        zero;
  logic        overflow;
  logic [31:0] out_q;

  modport master (
    output A32, B32, ALUop,
    input  out32, zero, overflow, out_q
  );

  modport slave (
    input  A32, B32, ALUop,
    output out32, zero, overflow, out_q
  );
endinterface

// File: rtl/alu.sv
// 32-bit MIPS integer ALU: combinational result/zero/overflow plus the
// ALUOut register that holds the result for later multicycle states.
module alu (
  input  logic   clk,
  input  logic   rst,
  alu_if.slave   bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 5;
  localparam int unsigned OW = 4;

  localparam logic [OW-1:0] OP_AND  = 4'b0000;
  localparam logic [OW-1:0] OP_OR   = 4'b0001;
  localparam logic [OW-1:0] OP_ADD  = 4'b0010;
  localparam logic [OW-1:0] OP_XOR  = 4'b0011;
  localparam logic [OW-1:0] OP_SLL  = 4'b0100;
  localparam logic [OW-1:0] OP_SRL  = 4'b0101;
  localparam logic [OW-1:0] OP_SUB  = 4'b0110;
  localparam logic [OW-1:0] OP_SLT  = 4'b0111;
  localparam logic [OW-1:0] OP_SRA  = 4'b1000;
  localparam logic [OW-1:0] OP_SLTU = 4'b1001;
  localparam logic [OW-1:0] OP_NOR  = 4'b1100;

  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [SW-1:0] shamt;
  logic [DW-1:0] sum;
  logic [DW-1:0] diff;
  logic          slt_s;
  logic          slt_u;
  logic          add_ovf;
  logic          sub_ovf;
  logic [DW-1:0] res;
  logic          ovf;

  assign a     = bus.A32;
  assign b     = bus.B32;
  assign shamt = bus.B32[SW-1:0];

  // Separate adder and subtractor so each overflow rule sees its own sign bit.
  assign sum  = a + b;
  assign diff = a - b;

  // True comparisons, independent of the wrapped subtraction result.
  assign slt_s = $signed(a) < $signed(b);
  assign slt_u = a < b;

  assign add_ovf = (a[DW-1] == b[DW-1]) && (sum[DW-1]  != a[DW-1]);
  assign sub_ovf = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);

  // Result and overflow select; undefined codes give a clean zero.
  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (bus.ALUop)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD:  begin
        res = sum;
        ovf = add_ovf;
      end
      OP_XOR:  res = a ^ b;
      OP_SLL:  res = a << shamt;
      OP_SRL:  res = a >> shamt;
      OP_SUB:  begin
        res = diff;
        ovf = sub_ovf;
      end
      OP_SLT:  res = DW'(slt_s);
      OP_SRA:  res = DW'($signed(a) >>> shamt);
      OP_SLTU: res = DW'(slt_u);
      OP_NOR:  res = ~(a | b);
      default: begin
        res = '0;
        ovf = 1'b0;
      end
    endcase
  end

  assign bus.out32    = res;
  assign bus.zero     = (res == '0);
  assign bus.overflow = ovf;

  // ALUOut: loads every cycle, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_q <= '0;
    end else begin
      bus.out_q <= res;
    end
  end
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, randomized checks against
// an arithmetic reference model, and ALUOut register/reset sequences.
module tb_alu;
  logic clk;
  logic rst;
  int   passed;
  int   total;

  alu_if bus ();

  alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp;
    logic        z;
    logic        ov;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model built from signed/unsigned integer arithmetic.
  task automatic ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         output logic [31:0] r, output logic z, output logic ov);
    longint sa, sb, s, p, q;
    longint unsigned ua, ub;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    sh = int'(b % 32);
    p  = longint'(1) << sh;
    ov = 1'b0;
    r  = 32'd0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  begin s = sa + sb; r = 32'(s); ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd3:  r = a ^ b;
      4'd4:  r = 32'(ua * longint'(p));
      4'd5:  r = 32'(ua / longint'(p));
      4'd6:  begin s = sa - sb; r = 32'(s); ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  begin
        q = sa / p;
        if ((sa % p != 0) && (sa < 0)) q = q - 1;
        r = 32'(q);
      end
      4'd9:  r = (ua < ub) ? 32'd1 : 32'd0;
      4'd12: r = ~(a | b);
      default: r = 32'd0;
    endcase
    z = (r == 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    bus.A32   = a;
    bus.B32   = b;
    bus.ALUop = op;
  endtask

  initial begin
    logic [31:0] er, prev;
    logic ez, eov;
    passed = 0;
    total  = 0;
    rst = 1'b1;
    drive(32'd0, 32'd0, 4'd0);

    vecs.push_back('{32'd7, 32'd3, 4'b0000, 32'd3, 1'b0, 1'b0});
    vecs.push_back('{32'd7, 32'd3, 4'b0001, 32'd7, 1'b0, 1'b0});
    vecs.push_back('{32'd7, 32'd3, 4'b0010, 32'd10, 1'b0, 1'b0});
    vecs.push_back('{32'd7, 32'd3, 4'b0110, 32'd4, 1'b0, 1'b0});
    vecs.push_back('{32'd7, 32'd3, 4'b0011, 32'd4, 1'b0, 1'b0});
    vecs.push_back('{32'd3, 32'd7, 4'b0110, 32'hFFFF_FFFC, 1'b0, 1'b0});
    vecs.push_back('{32'd3, 32'd7, 4'b0111, 32'd1, 1'b0, 1'b0});
    vecs.push_back('{32'd3, 32'd7, 4'b1001, 32'd1, 1'b0, 1'b0});
    vecs.push_back('{32'd7, 32'd3, 4'b0111, 32'd0, 1'b1, 1'b0});
    vecs.push_back('{32'd5, 32'd5, 4'b0110, 32'd0, 1'b1, 1'b0});
    vecs.push_back('{32'h7FFF_FFFF, 32'd1, 4'b0010, 32'h8000_0000, 1'b0, 1'b1});
    vecs.push_back('{32'h8000_0000, 32'd1, 4'b0110, 32'h7FFF_FFFF, 1'b0, 1'b1});
    vecs.push_back('{32'h8000_0000, 32'd1, 4'b0111, 32'd1, 1'b0, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'd1, 4'b1001, 32'd0, 1'b1, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'd0, 4'b0111, 32'd1, 1'b0, 1'b0});
    vecs.push_back('{32'h8000_00F0, 32'd4, 4'b0100, 32'h0000_0F00, 1'b0, 1'b0});
    vecs.push_back('{32'h8000_00F0, 32'd4, 4'b0101, 32'h0800_000F, 1'b0, 1'b0});
    vecs.push_back('{32'h8000_00F0, 32'd4, 4'b1000, 32'hF800_000F, 1'b0, 1'b0});
    vecs.push_back('{32'h8000_00F0, 32'h24, 4'b0100, 32'h0000_0F00, 1'b0, 1'b0});
    vecs.push_back('{32'h8000_00F0, 32'h24, 4'b1000, 32'hF800_000F, 1'b0, 1'b0});
    vecs.push_back('{32'd0, 32'd0, 4'b1100, 32'hFFFF_FFFF, 1'b0, 1'b0});
    vecs.push_back('{32'h1234_5678, 32'h9ABC_DEF0, 4'b1111, 32'd0, 1'b1, 1'b0});
    vecs.push_back('{32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b1010, 32'd0, 1'b1, 1'b0});
    vecs.push_back('{32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b1011, 32'd0, 1'b1, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'd1, 4'b1101, 32'd0, 1'b1, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'd1, 4'b1110, 32'd0, 1'b1, 1'b0});

    // Reset state, with combinational outputs still live during reset.
    #2;
    chk("reset out_q", bus.out_q, 32'd0);
    @(posedge clk); #1;
    chk("out_q held in reset", bus.out_q, 32'd0);

    // Directed table (combinational outputs only).
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b, vecs[i].op);
      #1;
      chk($sformatf("vec%0d out32", i), bus.out32, vecs[i].exp);
      chk($sformatf("vec%0d zero", i), 32'(bus.zero), 32'(vecs[i].z));
      chk($sformatf("vec%0d overflow", i), 32'(bus.overflow), 32'(vecs[i].ov));
    end
    chk("out_q still 0 in reset", bus.out_q, 32'd0);

    // Release reset; random stimulus, out_q tracks the previous cycle's result.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      logic [3:0] op;
      a  = pick();
      b  = pick();
      op = 4'($urandom_range(0, 15));
      drive(a, b, op);
      ref_alu(a, b, op, er, ez, eov);
      #1;
      chk($sformatf("rnd%0d op%0d out32", i, op), bus.out32, er);
      chk($sformatf("rnd%0d zero", i), 32'(bus.zero), 32'(ez));
      chk($sformatf("rnd%0d overflow", i), 32'(bus.overflow), 32'(eov));
      prev = er;
      @(posedge clk); #1;
      chk($sformatf("rnd%0d out_q", i), bus.out_q, prev);
      @(negedge clk);
    end

    // Async reset mid-cycle clears out_q without an edge.
    drive(32'd7, 32'd3, 4'b0010);
    @(posedge clk); #1;
    chk("out_q loaded before reset", bus.out_q, 32'd10);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async reset out_q", bus.out_q, 32'd0);
    chk("out32 valid in reset", bus.out32, 32'd10);
    @(posedge clk); #1;
    chk("out_q 0 while rst high", bus.out_q, 32'd0);

    // Release with ADD 7+3, then switch to SUB mid-cycle.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("out_q after release", bus.out_q, 32'd10);
    @(negedge clk);
    bus.ALUop = 4'b0110;
    #1;
    chk("out_q holds mid-cycle", bus.out_q, 32'd10);
    chk("out32 sub mid-cycle", bus.out32, 32'd4);
    @(posedge clk); #1;
    chk("out_q after sub edge", bus.out_q, 32'd4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
